// File: rtl/eel_if_pkg.sv
// Shared types and defaults for the instruction-fetch slice.
package eel_if_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam int unsigned     IMEM_ADDR_WIDTH  = 14;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One fetched instruction together with its byte address.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_entry_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry skid buffer with a registered output stage and a flush input.
// The output register is what the consumer sees; the skid entry catches a
// word that arrives while the output is being held.
module if_skid_buffer
    import eel_if_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      in_valid,
    input  if_entry_t in_entry,
    output logic      in_ready,
    output logic      out_valid,
    output if_entry_t out_entry,
    input  logic      out_ready
);

    logic      sk_valid;
    if_entry_t sk_entry;
    logic      fire;

    // Consumer handshake and upstream readiness (skid slot free).
    always_comb begin
        fire     = out_valid & out_ready;
        in_ready = ~sk_valid;
    end

    // Route the incoming word to out or skid; drain skid into out on a fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_entry <= '0;
            sk_valid  <= 1'b0;
            sk_entry  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            sk_valid  <= 1'b0;
        end else if (in_valid) begin
            if (!out_valid || (fire && !sk_valid)) begin
                out_valid <= 1'b1;
                out_entry <= in_entry;
            end else if (fire) begin
                out_entry <= sk_entry;
                sk_entry  <= in_entry;
            end else begin
                sk_valid  <= 1'b1;
                sk_entry  <= in_entry;
            end
        end else if (fire) begin
            if (sk_valid) begin
                out_entry <= sk_entry;
                sk_valid  <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // A word arriving while both out is held and skid is full would be lost.
    a_no_skid_overflow : assert property (
        @(posedge clk) disable iff (rst)
        !(in_valid && !flush && out_valid && !out_ready && sk_valid)
    );

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues IMEM reads, and hands
// {instruction, PC} to decode through a skid buffer with flush on redirect.
module if_fetch_unit
    import eel_if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  IMEM_RDEN,
    output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
    input  logic [XLEN-1:0]       IMEM_DATA,
    input  logic                  ID_READY,
    output logic                  IF_VALID,
    output logic [XLEN-1:0]       IF_INSTR,
    output logic [XLEN-1:0]       IF_PC,
    output logic [XLEN-1:0]       IF_PC_PLUS4,
    input  logic                  REDIRECT,
    input  logic [XLEN-1:0]       REDIRECT_PC
);

    logic [XLEN-1:0] fetch_pc;
    logic            ir_valid;
    logic [XLEN-1:0] ir_pc;
    logic [XLEN-1:0] redirect_target;
    logic            issue;
    logic            sk_ready;
    logic            out_valid;
    if_entry_t       ret_entry;
    if_entry_t       out_entry;

    // Issue decision; a stalled output with a word in flight blocks the next
    // request so the single skid entry can never overflow. RST also holds
    // RDEN low so no read is requested while the stage is in reset.
    always_comb begin
        redirect_target = REDIRECT_PC & ~32'd3;
        issue           = ~RST & ~REDIRECT & sk_ready
                          & ~(out_valid & ir_valid & ~ID_READY);
        IMEM_RDEN       = issue;
        IMEM_ADDR       = fetch_pc[ADDR_WIDTH+1:2];
        ret_entry.instr = IMEM_DATA;
        ret_entry.pc    = ir_pc;
    end

    // PC and in-flight request tracking; redirect wins over everything.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc <= RESET_PC;
            ir_valid <= 1'b0;
            ir_pc    <= '0;
        end else if (REDIRECT) begin
            fetch_pc <= redirect_target;
            ir_valid <= 1'b0;
        end else if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
            ir_valid <= 1'b1;
            ir_pc    <= fetch_pc;
        end else begin
            ir_valid <= 1'b0;
        end
    end

    if_skid_buffer u_skid (
        .clk       (CLK),
        .rst       (RST),
        .flush     (REDIRECT),
        .in_valid  (ir_valid),
        .in_entry  (ret_entry),
        .in_ready  (sk_ready),
        .out_valid (out_valid),
        .out_entry (out_entry),
        .out_ready (ID_READY)
    );

    // Decode-facing outputs; a redirect masks the output in its own cycle.
    always_comb begin
        IF_VALID    = out_valid & ~REDIRECT;
        IF_INSTR    = out_entry.instr;
        IF_PC       = out_entry.pc;
        IF_PC_PLUS4 = out_entry.pc + 32'd4;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with an IMEM model and a stream model.
module tb_if_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        IMEM_RDEN;
    logic [13:0] IMEM_ADDR;
    logic [31:0] IMEM_DATA;
    logic        ID_READY;
    logic        IF_VALID;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic [31:0] IF_PC_PLUS4;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;

    logic [31:0] mem [0:16383];

    int tests = 0;
    int fails = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_WIDTH(14)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IMEM_RDEN   (IMEM_RDEN),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_DATA   (IMEM_DATA),
        .ID_READY    (ID_READY),
        .IF_VALID    (IF_VALID),
        .IF_INSTR    (IF_INSTR),
        .IF_PC       (IF_PC),
        .IF_PC_PLUS4 (IF_PC_PLUS4),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous IMEM: one-cycle latency, garbage when not read.
    always @(posedge CLK) begin
        if (IMEM_RDEN) IMEM_DATA <= mem[IMEM_ADDR];
        else           IMEM_DATA <= $urandom;
    end

    // Word at byte address pc as preloaded: 0x1000_0000 + word index (mod 2^14).
    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return 32'h1000_0000 + {18'd0, pc[15:2]};
    endfunction

    // Advance to just after the next edge, then apply inputs for the new cycle.
    task automatic step(input logic rdy, input logic red, input logic [31:0] rpc);
        @(posedge CLK);
        #1;
        ID_READY    = rdy;
        REDIRECT    = red;
        REDIRECT_PC = rpc;
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", IF_VALID); end
        tests++; if (IMEM_RDEN !== 1'b0) begin fails++; $display("FAIL reset_rden: got %b expected 0", IMEM_RDEN); end
        tests++; if (IF_PC !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected 0", IF_PC); end
        tests++; if (IF_INSTR !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h expected 0", IF_INSTR); end
        tests++; if (IF_PC_PLUS4 !== 32'h4) begin fails++; $display("FAIL reset_plus4: got %h expected 4", IF_PC_PLUS4); end
    endtask

    task automatic test_stream();
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        tests++; if (IMEM_RDEN !== 1'b1 || IMEM_ADDR !== 14'd0) begin fails++; $display("FAIL stream_first_issue: got rden=%b addr=%h expected 1/0", IMEM_RDEN, IMEM_ADDR); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b0 || IMEM_ADDR !== 14'd1) begin fails++; $display("FAIL stream_latency: got valid=%b addr=%h expected 0/1", IF_VALID, IMEM_ADDR); end
        for (int k = 0; k < 10; k++) begin
            logic [31:0] pc;
            pc = 32'(k) * 4;
            step(1'b1, 1'b0, 32'h0);
            tests++; if (IF_VALID !== 1'b1 || IF_PC !== pc) begin fails++; $display("FAIL stream_pc: got valid=%b pc=%h expected 1/%h", IF_VALID, IF_PC, pc); end
            tests++; if (IF_INSTR !== exp_word(pc)) begin fails++; $display("FAIL stream_instr: got %h expected %h", IF_INSTR, exp_word(pc)); end
            tests++; if (IF_PC_PLUS4 !== pc + 32'd4) begin fails++; $display("FAIL stream_plus4: got %h expected %h", IF_PC_PLUS4, pc + 32'd4); end
            tests++; if (IMEM_RDEN !== 1'b1 || IMEM_ADDR !== 14'(k + 2)) begin fails++; $display("FAIL stream_addr: got rden=%b addr=%h expected 1/%h", IMEM_RDEN, IMEM_ADDR, 14'(k + 2)); end
        end
    endtask

    task automatic test_backpressure();
        logic        found;
        logic [31:0] exp;
        found = 1'b0;
        step(1'b1, 1'b1, 32'h0);
        for (int c = 0; c < 10 && !found; c++) begin
            step(1'b1, 1'b0, 32'h0);
            if (IF_VALID === 1'b1 && IF_PC === 32'h8) found = 1'b1;
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL bp_reach_pc8: got found=%b expected 1", found); end
        ID_READY = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 1'b0, 32'h0);
            tests++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h8 || IF_INSTR !== exp_word(32'h8)) begin fails++; $display("FAIL bp_hold: got valid=%b pc=%h instr=%h expected 1/8/%h", IF_VALID, IF_PC, IF_INSTR, exp_word(32'h8)); end
            tests++; if (IMEM_RDEN !== 1'b0) begin fails++; $display("FAIL bp_rden_drop: got %b expected 0", IMEM_RDEN); end
        end
        exp = 32'h8;
        for (int c = 0; c < 12 && exp != 32'd24; c++) begin
            step(1'b1, 1'b0, 32'h0);
            if (IF_VALID === 1'b1) begin
                tests++; if (IF_PC !== exp || IF_INSTR !== exp_word(exp)) begin fails++; $display("FAIL bp_resume_order: got pc=%h instr=%h expected %h/%h", IF_PC, IF_INSTR, exp, exp_word(exp)); end
                exp = exp + 32'd4;
            end
        end
        tests++; if (exp !== 32'd24) begin fails++; $display("FAIL bp_resume_count: got next pc %h expected 18", exp); end
    endtask

    task automatic test_redirect();
        logic found;
        found = 1'b0;
        step(1'b1, 1'b1, 32'h200);
        for (int c = 0; c < 6 && !found; c++) begin
            step(1'b1, 1'b0, 32'h0);
            if (IF_VALID === 1'b1) found = 1'b1;
        end
        tests++; if (found !== 1'b1 || IF_PC !== 32'h200) begin fails++; $display("FAIL redir_setup: got found=%b pc=%h expected 1/200", found, IF_PC); end
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0043);
        tests++; if (IF_VALID !== 1'b0 || IMEM_RDEN !== 1'b0) begin fails++; $display("FAIL redir_cycle: got valid=%b rden=%b expected 0/0", IF_VALID, IMEM_RDEN); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IMEM_ADDR !== 14'd16 || IMEM_RDEN !== 1'b1 || IF_VALID !== 1'b0) begin fails++; $display("FAIL redir_addr: got addr=%h rden=%b valid=%b expected 10/1/0", IMEM_ADDR, IMEM_RDEN, IF_VALID); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b0) begin fails++; $display("FAIL redir_no_stale: got valid=%b pc=%h expected 0", IF_VALID, IF_PC); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h40 || IF_INSTR !== exp_word(32'h40)) begin fails++; $display("FAIL redir_first: got valid=%b pc=%h instr=%h expected 1/40/%h", IF_VALID, IF_PC, IF_INSTR, exp_word(32'h40)); end
    endtask

    task automatic test_redirect_burst();
        logic [31:0] tgt;
        for (int r = 1; r <= 3; r++) begin
            tgt = 32'(r) * 32'h100;
            step(1'b1, 1'b1, tgt);
            tests++; if (IMEM_RDEN !== 1'b0 || IF_VALID !== 1'b0) begin fails++; $display("FAIL burst_quiet: got rden=%b valid=%b expected 0/0", IMEM_RDEN, IF_VALID); end
        end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IMEM_RDEN !== 1'b1 || IMEM_ADDR !== 14'h0C0) begin fails++; $display("FAIL burst_addr: got rden=%b addr=%h expected 1/0c0", IMEM_RDEN, IMEM_ADDR); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b0) begin fails++; $display("FAIL burst_no_stale: got valid=%b expected 0", IF_VALID); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h300) begin fails++; $display("FAIL burst_last_wins: got valid=%b pc=%h expected 1/300", IF_VALID, IF_PC); end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b1, 32'h0000_FFFC);
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IMEM_ADDR !== 14'h3FFF || IMEM_RDEN !== 1'b1) begin fails++; $display("FAIL wrap_addr_top: got addr=%h rden=%b expected 3fff/1", IMEM_ADDR, IMEM_RDEN); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IMEM_ADDR !== 14'h0000) begin fails++; $display("FAIL wrap_addr_zero: got %h expected 0", IMEM_ADDR); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b1 || IF_PC !== 32'hFFFC || IF_INSTR !== 32'h1000_3FFF || IF_PC_PLUS4 !== 32'h1_0000) begin fails++; $display("FAIL wrap_out_top: got v=%b pc=%h instr=%h p4=%h expected 1/fffc/10003fff/10000", IF_VALID, IF_PC, IF_INSTR, IF_PC_PLUS4); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h1_0000 || IF_INSTR !== 32'h1000_0000) begin fails++; $display("FAIL wrap_out_next: got v=%b pc=%h instr=%h expected 1/10000/10000000", IF_VALID, IF_PC, IF_INSTR); end
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b1 || IF_PC !== 32'hFFFF_FFFC || IF_PC_PLUS4 !== 32'h0) begin fails++; $display("FAIL wrap32_top: got v=%b pc=%h p4=%h expected 1/fffffffc/0", IF_VALID, IF_PC, IF_PC_PLUS4); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h0 || IF_INSTR !== exp_word(32'h0)) begin fails++; $display("FAIL wrap32_next: got v=%b pc=%h instr=%h expected 1/0/%h", IF_VALID, IF_PC, IF_INSTR, exp_word(32'h0)); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        tests++; if (IF_VALID !== 1'b0 || IMEM_RDEN !== 1'b0) begin fails++; $display("FAIL arst_immediate: got valid=%b rden=%b expected 0/0", IF_VALID, IMEM_RDEN); end
        tests++; if (IF_PC !== 32'h0 || IF_INSTR !== 32'h0 || IF_PC_PLUS4 !== 32'h4) begin fails++; $display("FAIL arst_data: got pc=%h instr=%h p4=%h expected 0/0/4", IF_PC, IF_INSTR, IF_PC_PLUS4); end
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        tests++; if (IMEM_RDEN !== 1'b1 || IMEM_ADDR !== 14'd0) begin fails++; $display("FAIL arst_restart: got rden=%b addr=%h expected 1/0", IMEM_RDEN, IMEM_ADDR); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b0) begin fails++; $display("FAIL arst_no_stale: got valid=%b pc=%h expected 0", IF_VALID, IF_PC); end
        step(1'b1, 1'b0, 32'h0);
        tests++; if (IF_VALID !== 1'b1 || IF_PC !== 32'h0 || IF_INSTR !== exp_word(32'h0)) begin fails++; $display("FAIL arst_first: got v=%b pc=%h instr=%h expected 1/0/%h", IF_VALID, IF_PC, IF_INSTR, exp_word(32'h0)); end
    endtask

    // Random handshake and redirects against an in-order stream model.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic        prev_stall;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        int          idle;
        logic        rdy;
        logic        red;
        logic [31:0] rpc;
        step(1'b1, 1'b1, 32'h2000);
        exp_pc     = 32'h2000;
        prev_stall = 1'b0;
        prev_pc    = '0;
        prev_instr = '0;
        idle       = 0;
        for (int n = 0; n < 600; n++) begin
            rdy = ($urandom_range(0, 9) < 7);
            red = ($urandom_range(0, 31) == 0);
            rpc = $urandom;
            step(rdy, red, rpc);
            if (red) begin
                tests++; if (IF_VALID !== 1'b0 || IMEM_RDEN !== 1'b0) begin fails++; $display("FAIL rand_redirect: got valid=%b rden=%b expected 0/0", IF_VALID, IMEM_RDEN); end
                exp_pc     = {rpc[31:2], 2'b00};
                prev_stall = 1'b0;
                idle       = 0;
            end else begin
                if (prev_stall) begin
                    tests++; if (IF_VALID !== 1'b1 || IF_PC !== prev_pc || IF_INSTR !== prev_instr) begin fails++; $display("FAIL rand_hold: got v=%b pc=%h instr=%h expected 1/%h/%h", IF_VALID, IF_PC, IF_INSTR, prev_pc, prev_instr); end
                end
                if (IF_VALID === 1'b1 && rdy) begin
                    tests++; if (IF_PC !== exp_pc || IF_INSTR !== exp_word(exp_pc) || IF_PC_PLUS4 !== exp_pc + 32'd4) begin fails++; $display("FAIL rand_stream: got pc=%h instr=%h p4=%h expected %h/%h/%h", IF_PC, IF_INSTR, IF_PC_PLUS4, exp_pc, exp_word(exp_pc), exp_pc + 32'd4); end
                    exp_pc = exp_pc + 32'd4;
                    idle   = 0;
                end else if (rdy) begin
                    idle++;
                    tests++; if (idle > 6) begin fails++; $display("FAIL rand_progress: got %0d idle ready cycles expected at most 6", idle); end
                end
                prev_stall = (IF_VALID === 1'b1) && !rdy;
                prev_pc    = IF_PC;
                prev_instr = IF_INSTR;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 16384; k++) mem[k] = 32'h1000_0000 + 32'(k);
        RST         = 1'b1;
        ID_READY    = 1'b1;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_burst();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
